// File: rtl/safe_pkg.sv
// Shared definitions between the keypad front end and the safe lock FSM:
// key codes, debounce state encoding and frame classification.
package safe_pkg;

  localparam logic [3:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'ha, KEY_B = 4'hb;
  localparam logic [3:0] KEY_C = 4'hc, KEY_D = 4'hd, KEY_E = 4'he, KEY_F = 4'hf;

  typedef enum logic [1:0] {IDLE, DEB, HELD, REL} deb_state_t;

  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_GHOST} frame_kind_t;

  typedef struct packed {
    frame_kind_t kind;
    logic [3:0]  code;
  } frame_res_t;

  // Bit index row*4+col of the 16 frame samples is exactly the key code.
  function automatic frame_res_t classify(input logic [15:0] bits);
    frame_res_t  r;
    int unsigned n;
    n      = 0;
    r.kind = FR_NONE;
    r.code = '0;
    for (int i = 0; i < 16; i++) begin
      if (bits[i]) begin
        n++;
        r.code = 4'(i);
      end
    end
    if (n == 1)     r.kind = FR_SINGLE;
    else if (n > 1) r.kind = FR_GHOST;
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad-side and lock-side signals of keypad_entry; master is the scanner.
interface keypad_entry_if;
  logic [3:0] row_drive;
  logic [3:0] col_sense;
  logic [3:0] din;
  logic       din_valid;
  logic       key_held;

  modport master (output row_drive, din, din_valid, key_held, input  col_sense);
  modport slave  (input  row_drive, din, din_valid, key_held, output col_sense);
endinterface

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser, synchronous active-low reset.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with frame-level debounce; emits one din/din_valid
// pulse per accepted press, no auto-repeat while held.
module keypad_entry
  import safe_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  keypad_entry_if.master kp
);
  localparam int SLOT_W = $clog2(SCAN_DIV);

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        row_idx;
  logic [11:0]       acc;
  logic [3:0]        col_s;
  logic              last_slot, frame_end;
  frame_res_t        fr;

  deb_state_t        state;
  logic [3:0]        cand;
  logic [7:0]        cnt;

  sync2 #(.W(4)) u_col_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (kp.col_sense),
    .q       (col_s)
  );

  assign kp.row_drive = 4'b0001 << row_idx;
  assign last_slot    = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign frame_end    = last_slot && (row_idx == 2'd3);
  // Row 3 is folded in live so the frame is judged on its final sample edge.
  assign fr           = classify({col_s, acc});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      row_idx  <= '0;
      acc      <= '0;
    end else if (last_slot) begin
      slot_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
      case (row_idx)
        2'd0:    acc[3:0]  <= col_s;
        2'd1:    acc[7:4]  <= col_s;
        2'd2:    acc[11:8] <= col_s;
        default: ;
      endcase
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cand         <= '0;
      cnt          <= '0;
      kp.din       <= '0;
      kp.din_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      kp.din_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: if (fr.kind == FR_SINGLE) begin
            if (DEBOUNCE <= 1) begin
              kp.din       <= fr.code;
              kp.din_valid <= 1'b1;
              kp.key_held  <= 1'b1;
              state        <= HELD;
            end else begin
              cand  <= fr.code;
              cnt   <= 8'd1;
              state <= DEB;
            end
          end
          DEB: begin
            if (fr.kind != FR_SINGLE) begin
              state <= IDLE;
            end else if (fr.code != cand) begin
              cand <= fr.code;
              cnt  <= 8'd1;
            end else if (cnt >= 8'(DEBOUNCE - 1)) begin
              kp.din       <= cand;
              kp.din_valid <= 1'b1;
              kp.key_held  <= 1'b1;
              state        <= HELD;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          // A ghost frame counts as no key, so it starts the release count.
          HELD: if (fr.kind != FR_SINGLE) begin
            cnt   <= 8'd1;
            state <= REL;
          end
          REL: begin
            if (fr.kind == FR_SINGLE) begin
              state <= HELD;
            end else if (cnt >= 8'(DEBOUNCE - 1)) begin
              kp.key_held <= 1'b0;
              state       <= IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Upstream front end for the `safe` lock FSM. It scans a 4x4 matrix keypad, synchronises and debounces the column returns, and emits exactly one `din`/`din_valid` pulse per debounced key press. The outputs connect directly to the lock's `din`/`din_valid` inputs on the same clock. Holding a key produces no auto-repeat; no further code is emitted until the key is debounced-released.

## Interface
- `SCAN_DIV`, default 4: cycles each row is driven; legal minimum 4.
- `DEBOUNCE`, default 3: consecutive identical scan frames needed to accept a press, and to accept a release.
- `clk`  in  1  single clock; all logic is posedge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `row_drive`  out  4  one-hot row strobe, active-high.
- `col_sense`  in  4  column returns, active-high, asynchronous to `clk`.
- `din`  out  4  key code of the last accepted press.
- `din_valid`  out  1  one-cycle pulse when `din` is newly accepted.
- `key_held`  out  1  high while a press is accepted and not yet released.

## Operation
- `col_sense` passes through a 2-flop synchroniser before any use.
- Scanner:
  - `slot_cnt` counts 0..SCAN_DIV-1; `row_idx` counts 0..3; `row_drive = 1 << row_idx`.
  - On `slot_cnt == SCAN_DIV-1`, the synchronised columns are sampled for `row_idx`, then `row_idx` advances, wrapping 3→0.
- Frame: 4 slots (4*SCAN_DIV cycles). A frame is evaluated once the row-3 sample is taken.
  - Exactly one bit set across all 16 samples gives a single key. Its code is `{row[1:0], col[1:0]}`, e.g. row3/col0 = 4'hc, row0/col0 = 4'h0, row3/col3 = 4'hf.
  - Zero bits set gives none.
  - Two or more bits set is ghost/ambiguous and is treated as none.
- Debounce FSM (evaluated at frame end only):
  - IDLE
    - single key k: go to DEB, cand=k, cnt=1.
    - Special case DEBOUNCE=1: emit immediately and go to HELD.
  - DEB
    - same k: cnt++. When cnt reaches DEBOUNCE: din=k, pulse `din_valid`, go to HELD.
    - different single key j: cand=j, cnt=1, stay in DEB.
    - none: go to IDLE.
  - HELD
    - none: go to REL, cnt=1.
    - any key, including a different one: stay in HELD with no emit.
  - REL
    - none: cnt++. When cnt reaches DEBOUNCE: go to IDLE.
    - any key: go to HELD, with no emit.
- `key_held` = state is HELD or REL.
- `din` holds its value until the next accepted press.

## Timing
- Reset values (cycle after `reset_n` sampled low):
  - `row_drive` = 4'b0001, `din` = 4'h0, `din_valid` = 0, `key_held` = 0.
  - FSM in IDLE; all counters and synchroniser flops 0.
- Reset mid-operation discards any partial frame or debounce. Scanning restarts at row 0 when `reset_n` returns high.
- Frame-end evaluation is registered, so `din`/`din_valid` update one cycle after the row-3 sample cycle.
- Press latency: a clean, stable press is emitted no earlier than DEBOUNCE frames and no later than (DEBOUNCE+1) frames plus 3 cycles after contact (synchroniser plus evaluation register).
- `din_valid` is never high on consecutive cycles. Minimum spacing between pulses is 2*DEBOUNCE frames.
- No back-pressure: the lock accepts every `din_valid`.

## Structure
- Shared package `safe_pkg` holds:
  - 4-bit key-code constants (KEY_0..KEY_F).
  - Debounce FSM state encoding (IDLE, DEB, HELD, REL).
  - Frame-result encoding (none / single / ghost).
- One sub-module: `sync2` (parameterised-width 2-flop synchroniser, active-low synchronous reset), instantiated for `col_sense`.
- Scanner counters, frame accumulator, and FSM live in `keypad_entry`.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles).
1. Reset: hold `reset_n`=0 for 2 cycles → `row_drive`=0001, `din`=0, `din_valid`=0, `key_held`=0. After release, `row_drive` steps 0001→0010→0100→1000→0001 every 4 cycles.
2. Single press: assert row3/col0 contact for 120 cycles → exactly one `din_valid` pulse, `din`=4'hc, within 67 cycles of contact. `key_held`=1 until 3 none-frames after release.
3. Code entry: presses c,0,d,e, each held 100 cycles with 100-cycle gaps → four pulses in order (4'hc, 4'h0, 4'hd, 4'he). With the block wired to `safe`, `unlocked`=1 after the fourth pulse.
4. Bounce: row0/col1 toggles every 10 cycles for 80 cycles, then opens → no `din_valid`; FSM ends in IDLE.
5. Ghost: row0/col0 and row0/col1 held together for 80 cycles → no pulse. Then drop col1 and hold col0 → one pulse, `din`=4'h0.
6. Reset mid-debounce: press row3/col3, and pull `reset_n` low for 1 cycle after 2 frames → no pulse. Hold the key 100 more cycles → one pulse, `din`=4'hf.
